// File: rtl/exec_pkg.sv
// Shared definitions for the execute sequencer: opcodes, instruction field
// layout and the FSM state encoding.
package exec_pkg;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;

  // Instruction field positions: op[15:12] rd[11:8] rs1[7:4] rs2[3:0], imm8 = [7:0]
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int IMM_LSB = 0;

  // Opcodes; ALU opcodes map straight onto alu_oper via op[1:0]
  localparam logic [FIELD_W-1:0] OP_ADD = 4'd0;
  localparam logic [FIELD_W-1:0] OP_SUB = 4'd1;
  localparam logic [FIELD_W-1:0] OP_MUL = 4'd2;
  localparam logic [FIELD_W-1:0] OP_SLT = 4'd3;
  localparam logic [FIELD_W-1:0] OP_LI  = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // True for the four register-register ALU opcodes
  function automatic logic op_is_alu(input logic [FIELD_W-1:0] op);
    return (op <= OP_SLT);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational instruction decoder: splits the 16-bit word into
// register fields and classifies the opcode.
module instr_decode
  import exec_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [FIELD_W-1:0] rd,
  output logic [FIELD_W-1:0] rs1,
  output logic [FIELD_W-1:0] rs2,
  output logic [IMM_W-1:0]   imm8,
  output logic [1:0]         alu_oper,
  output logic               is_alu,
  output logic               is_li,
  output logic               is_illegal
);

  logic [FIELD_W-1:0] op;

  // Field extraction and opcode classification
  always_comb begin
    op         = instr[OP_LSB  +: FIELD_W];
    rd         = instr[RD_LSB  +: FIELD_W];
    rs1        = instr[RS1_LSB +: FIELD_W];
    rs2        = instr[RS2_LSB +: FIELD_W];
    imm8       = instr[IMM_LSB +: IMM_W];
    alu_oper   = op[1:0];
    is_alu     = op_is_alu(op);
    is_li      = (op == OP_LI);
    is_illegal = !is_alu && !is_li;
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle execute sequencer. Accepts one instruction at a time, reads the
// external register file, drives the external ALU and writes the result back.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both 1. instr_ready depends on the FSM state only (high in
// IDLE), so a requester may hold or drop instr_valid at will while busy.
//
// Timeline for an ALU op accepted at edge E0:
//   READ [E0,E1)  rf_ra1/rf_ra2 = rs1/rs2, operands captured at E1
//   EXEC [E1,E2)  alu_* driven from operand regs, result captured at E2
//   WB   [E2,E3)  rf_we/done high for this one cycle
// LI goes straight to WB; illegal opcodes spend one cycle in ERR.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [ADDR_W-1:0] rf_ra1,
  output logic [ADDR_W-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              rf_we,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [1:0]        alu_oper,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              done,
  output logic              illegal,
  output logic              zero_flag,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  // Decoded view of the instruction currently offered on the input
  logic [FIELD_W-1:0] dec_rd;
  logic [FIELD_W-1:0] dec_rs1;
  logic [FIELD_W-1:0] dec_rs2;
  logic [IMM_W-1:0]   dec_imm8;
  logic [1:0]         dec_alu_oper;
  logic               dec_is_alu;
  logic               dec_is_li;
  logic               dec_is_illegal;

  instr_decode u_decode (
    .instr      (instr),
    .rd         (dec_rd),
    .rs1        (dec_rs1),
    .rs2        (dec_rs2),
    .imm8       (dec_imm8),
    .alu_oper   (dec_alu_oper),
    .is_alu     (dec_is_alu),
    .is_li      (dec_is_li),
    .is_illegal (dec_is_illegal)
  );

  state_e             state_q,     state_d;
  logic [ADDR_W-1:0]  rd_q,        rd_d;        // destination held across READ/EXEC
  logic [1:0]         pend_oper_q, pend_oper_d; // opcode held until EXEC
  logic [DATA_W-1:0]  opa_q,       opa_d;       // operand registers
  logic [DATA_W-1:0]  opb_q,       opb_d;
  logic [1:0]         alu_oper_q,  alu_oper_d;
  logic [ADDR_W-1:0]  rf_ra1_q,    rf_ra1_d;
  logic [ADDR_W-1:0]  rf_ra2_q,    rf_ra2_d;
  logic [ADDR_W-1:0]  rf_wa_q,     rf_wa_d;
  logic [DATA_W-1:0]  rf_wd_q,     rf_wd_d;     // doubles as the captured result
  logic               rf_we_q,     rf_we_d;
  logic               done_q,      done_d;
  logic               illegal_q,   illegal_d;
  logic               zero_flag_q, zero_flag_d;

  // Next-state and registered-output computation; pulses default low and
  // are raised only on the edge that enters WB or ERR.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    pend_oper_d = pend_oper_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    alu_oper_d  = alu_oper_q;
    rf_ra1_d    = rf_ra1_q;
    rf_ra2_d    = rf_ra2_q;
    rf_wa_d     = rf_wa_q;
    rf_wd_d     = rf_wd_q;
    rf_we_d     = 1'b0;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    zero_flag_d = zero_flag_q;

    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          if (dec_is_illegal) begin
            state_d   = ST_ERR;
            illegal_d = 1'b1;
          end else if (dec_is_li) begin
            state_d = ST_WB;
            rf_we_d = 1'b1;
            done_d  = 1'b1;
            rf_wa_d = ADDR_W'(dec_rd);
            rf_wd_d = {{(DATA_W-IMM_W){1'b0}}, dec_imm8};
          end else if (dec_is_alu) begin
            state_d     = ST_READ;
            rd_d        = ADDR_W'(dec_rd);
            pend_oper_d = dec_alu_oper;
            rf_ra1_d    = ADDR_W'(dec_rs1);
            rf_ra2_d    = ADDR_W'(dec_rs2);
          end
        end
      end
      ST_READ: begin
        state_d    = ST_EXEC;
        opa_d      = rf_rd1;
        opb_d      = rf_rd2;
        alu_oper_d = pend_oper_q;
      end
      ST_EXEC: begin
        state_d     = ST_WB;
        rf_we_d     = 1'b1;
        done_d      = 1'b1;
        rf_wa_d     = rd_q;
        rf_wd_d     = alu_result;
        zero_flag_d = alu_zero;
      end
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_q        <= '0;
      pend_oper_q <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      alu_oper_q  <= '0;
      rf_ra1_q    <= '0;
      rf_ra2_q    <= '0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
      rf_we_q     <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      pend_oper_q <= pend_oper_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      alu_oper_q  <= alu_oper_d;
      rf_ra1_q    <= rf_ra1_d;
      rf_ra2_q    <= rf_ra2_d;
      rf_wa_q     <= rf_wa_d;
      rf_wd_q     <= rf_wd_d;
      rf_we_q     <= rf_we_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;
  assign rf_ra1      = rf_ra1_q;
  assign rf_ra2      = rf_ra2_q;
  assign rf_wa       = rf_wa_q;
  assign rf_wd       = rf_wd_q;
  assign rf_we       = rf_we_q;
  assign alu_op1     = opa_q;
  assign alu_op2     = opb_q;
  assign alu_oper    = alu_oper_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign zero_flag   = zero_flag_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: external register file and ALU, a driver that
// issues instructions, a reference model that predicts every write-back or
// illegal pulse, and a monitor that compares DUT outputs against it.
module tb_exec_sequencer;

  localparam int AW = 4;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  logic [AW-1:0] rf_ra1, rf_ra2, rf_wa;
  logic [DW-1:0] rf_rd1, rf_rd2, rf_wd;
  logic          rf_we;
  logic [DW-1:0] alu_op1, alu_op2, alu_result;
  logic [1:0]    alu_oper;
  logic          alu_zero;
  logic          done, illegal, zero_flag, busy;
  logic [2:0]    dbg_state;

  exec_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_ra1      (rf_ra1),
    .rf_ra2      (rf_ra2),
    .rf_rd1      (rf_rd1),
    .rf_rd2      (rf_rd2),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .rf_we       (rf_we),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_oper    (alu_oper),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .done        (done),
    .illegal     (illegal),
    .zero_flag   (zero_flag),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- environment: register file and ALU ----------------
  logic [DW-1:0] env_rf [16];
  assign rf_rd1 = env_rf[rf_ra1];
  assign rf_rd2 = env_rf[rf_ra2];

  always @(posedge clk) begin
    if (rf_we) env_rf[rf_wa] <= rf_wd;
  end

  always_comb begin
    case (alu_oper)
      2'd0:    alu_result = alu_op1 + alu_op2;
      2'd1:    alu_result = alu_op1 - alu_op2;
      2'd2:    alu_result = alu_op1 * alu_op2;
      default: alu_result = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
    endcase
    alu_zero = (alu_result == '0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          is_ill;
    logic [3:0]    wa;
    logic [31:0]   wd;
    logic          zf;
    int            acc;   // edge count of the accepting edge
    int            lat;   // edges from accept to the cycle the pulse is visible
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_rf [16];
  logic        ref_zero;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural effect of one instruction, computed from the ISA rules
  function automatic void model(input logic [15:0] w);
    exp_t        e;
    logic [3:0]  op  = w[15:12];
    logic [3:0]  rd  = w[11:8];
    logic [31:0] a   = ref_rf[w[7:4]];
    logic [31:0] b   = ref_rf[w[3:0]];
    logic [31:0] res = 32'd0;
    e.acc    = cyc + 1;
    e.is_ill = 1'b0;
    e.wa     = rd;
    if (op == 4'd4) begin
      res = {24'd0, w[7:0]};
      e.lat = 0;
    end else if (op < 4'd4) begin
      if (op == 4'd0)      res = a + b;
      else if (op == 4'd1) res = a - b;
      else if (op == 4'd2) res = 32'(longint'(a) * longint'(b));
      else                 res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      ref_zero = (res == 32'd0);
      e.lat = 2;
    end else begin
      e.is_ill = 1'b1;
      e.lat = 0;
    end
    if (!e.is_ill) ref_rf[rd] = res;
    e.wd = res;
    e.zf = ref_zero;
    exp_q.push_back(e);
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    logic prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("ready_is_not_busy", {31'd0, instr_ready}, {31'd0, !busy});
        if (rf_we) check("we_single_cycle", {31'd0, prev_we}, 32'd0);
        if (rf_we || done || illegal) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", {29'd0, rf_we, done, illegal}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
            check("zero_flag", {31'd0, zero_flag}, {31'd0, e.zf});
            if (e.is_ill) begin
              check("illegal_strobes", {29'd0, rf_we, done, illegal}, 32'b001);
            end else begin
              check("wb_strobes", {29'd0, rf_we, done, illegal}, 32'b110);
              check("rf_wa", {28'd0, rf_wa}, {28'd0, e.wa});
              check("rf_wd", rf_wd, e.wd);
            end
          end
        end
        prev_we = rf_we;
      end else begin
        prev_we = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  // Waits for IDLE, then offers w for exactly the accepting edge. While the
  // sequencer is busy, either keep offering w (hold) or toggle junk.
  task automatic issue(input logic [15:0] w, input bit hold, input int gap);
    int guard = 0;
    repeat (gap) begin
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = 16'($urandom);
    end
    forever begin
      @(negedge clk);
      if (instr_ready) begin
        instr_valid = 1'b1;
        instr       = w;
        model(w);
        break;
      end
      instr_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
      instr       = hold ? w : 16'($urandom);
      guard++;
      if (guard > 20) begin
        check("ready_timeout", {31'd0, instr_ready}, 32'd1);
        break;
      end
    end
    @(posedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      instr_valid = 1'b0;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_we"},     {31'd0, rf_we},     32'd0);
    check({tag, "_done"},      {31'd0, done},      32'd0);
    check({tag, "_illegal"},   {31'd0, illegal},   32'd0);
    check({tag, "_zero_flag"}, {31'd0, zero_flag}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_alu_op1"},   alu_op1,            32'd0);
    check({tag, "_alu_op2"},   alu_op2,            32'd0);
    check({tag, "_alu_oper"},  {30'd0, alu_oper},  32'd0);
    check({tag, "_rf_ra"},     {24'd0, rf_ra1, rf_ra2}, 32'd0);
    check({tag, "_rf_wa"},     {28'd0, rf_wa},     32'd0);
    check({tag, "_rf_wd"},     rf_wd,              32'd0);
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  function automatic logic [15:0] li(input logic [3:0] rd, input logic [7:0] imm);
    return {4'h4, rd, imm};
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] saved_rf [16];
    logic [15:0] w;
    logic [3:0]  op, rs1, rs2;

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'd0;
    ref_zero    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      env_rf[i] = $urandom;
      ref_rf[i] = env_rf[i];
    end
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_reset", {31'd0, instr_ready}, 32'd1);

    // Directed: arithmetic, zero flag, LI keeps flag, illegal, SLT, dependency
    issue(li(4'd1, 8'd7), 0, 0);
    issue(li(4'd2, 8'd5), 0, 0);
    issue(mk(4'h0, 4'd3, 4'd1, 4'd2), 0, 1);    // 7 + 5 = 12
    issue(li(4'd1, 8'd9), 0, 0);
    issue(li(4'd2, 8'd9), 0, 0);
    issue(mk(4'h1, 4'd4, 4'd1, 4'd2), 0, 0);    // 9 - 9 = 0, flag set
    issue(li(4'd4, 8'hA5), 0, 0);                // flag stays set
    issue(16'hF123, 0, 0);                       // illegal
    issue(li(4'd0, 8'd0), 0, 0);                 // r0 is an ordinary register
    issue(li(4'd5, 8'd1), 0, 0);
    issue(mk(4'h1, 4'd1, 4'd0, 4'd5), 0, 0);    // r1 = 0 - 1 = 0xFFFFFFFF
    issue(li(4'd2, 8'd1), 0, 0);
    issue(mk(4'h3, 4'd6, 4'd1, 4'd2), 0, 0);    // -1 < 1 signed -> 1
    issue(mk(4'h2, 4'd7, 4'd3, 4'd3), 0, 0);    // 12 * 12 = 144
    issue(mk(4'h0, 4'd8, 4'd7, 4'd2), 0, 0);    // depends on r7: 145
    // Valid held high with queued ops: accepts only in IDLE
    issue(mk(4'h0, 4'd9, 4'd8, 4'd8), 1, 0);
    issue(li(4'd10, 8'h3C), 1, 0);
    issue(mk(4'h1, 4'd11, 4'd9, 4'd10), 1, 0);
    wait_drain();

    // Reset while an ADD sits in EXEC: no write may ever appear
    for (int i = 0; i < 16; i++) saved_rf[i] = ref_rf[i];
    issue(mk(4'h0, 4'd12, 4'd1, 4'd2), 0, 0);
    @(negedge clk);
    @(negedge clk);
    $display("reset asserted with dbg_state=%0d busy=%0b", dbg_state, busy);
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    void'(exp_q.pop_back());
    for (int i = 0; i < 16; i++) ref_rf[i] = saved_rf[i];
    ref_zero = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_midreset", {31'd0, instr_ready}, 32'd1);
    repeat (4) @(negedge clk);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      op  = 4'($urandom_range(0, 5));
      if (op == 4'd5) op = 4'($urandom_range(5, 15));
      rs1 = 4'($urandom_range(0, 15));
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : 4'($urandom_range(0, 15));
      w   = {op, 4'($urandom_range(0, 15)), rs1, rs2};
      issue(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
    wait_drain();
    repeat (3) @(negedge clk);

    for (int i = 0; i < 16; i++) check($sformatf("rf_final_r%0d", i), env_rf[i], ref_rf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
